// File: rtl/systolic_edge_feeder_pkg.sv
// rtl/systolic_edge_feeder_pkg.sv - shared control codes, FSM encoding and drain length for the edge feeder
package systolic_edge_feeder_pkg;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_LOAD = 2'b01;
    localparam logic [1:0] CTRL_COMP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } feeder_state_t;

    // Cycles needed for the last skewed activation to cross the whole grid.
    function automatic int drain_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/systolic_edge_feeder_skew_delay_line.sv
// rtl/systolic_edge_feeder_skew_delay_line.sv - resettable DEPTH-stage delay line, DEPTH=0 is a wire
module skew_delay_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, reset};
        assign out_data  = in_data;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign out_data = pipe[DEPTH-1];
    end

endmodule

// File: rtl/systolic_edge_feeder.sv
// rtl/systolic_edge_feeder.sv - left/top edge feeder for the weight-stationary array
// Optional perf counters under FEEDER_PERF_CNT_EN.
module systolic_edge_feeder
    import systolic_edge_feeder_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [COLS*WORD_WIDTH*4-1:0] w_data,
    input  logic                         act_valid,
    output logic                         act_ready,
    input  logic [ROWS*WORD_WIDTH-1:0]   act_data,
    input  logic                         act_last,
    output logic [1:0]                   ctrl_out,
    output logic [COLS*WORD_WIDTH*4-1:0] d_out,
    output logic [ROWS*WORD_WIDTH-1:0]   a_out,
    output logic [ROWS-1:0]              a_vld,
    output logic                         busy,
    output logic                         done
`ifdef FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_compute_cycles,
    output logic [31:0]                  perf_bubble_cycles
`endif
);

    localparam int CW = $clog2(ROWS + COLS) + 1;
    localparam logic [CW-1:0] BEAT_LAST  = CW'(ROWS - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_cycles(ROWS, COLS) - 1);

    feeder_state_t   state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [1:0]      ctrl_next;
    logic            w_fire, act_fire, in_array, next_in_array;

    assign w_fire        = w_valid && w_ready;
    assign act_fire      = act_valid && act_ready;
    assign in_array      = (state == ST_COMPUTE) || (state == ST_DRAIN);
    assign next_in_array = (state_next == ST_COMPUTE) || (state_next == ST_DRAIN);

    // One counter serves both phases: beat index in IDLE/LOAD, drain cycle in DRAIN.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (w_fire) begin
                    if (cnt == BEAT_LAST) begin
                        state_next = ST_COMPUTE;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_LOAD;
                        cnt_next   = cnt + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (act_fire && act_last) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Compute code is dropped on the cycle after the final drain cycle.
    always_comb begin
        ctrl_next = CTRL_IDLE;
        if (w_fire)
            ctrl_next = CTRL_LOAD;
        else if (in_array && next_in_array)
            ctrl_next = CTRL_COMP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ctrl_out  <= CTRL_IDLE;
            d_out     <= '0;
            w_ready   <= 1'b0;
            act_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            ctrl_out  <= ctrl_next;
            w_ready   <= (state_next == ST_IDLE) || (state_next == ST_LOAD);
            act_ready <= (state_next == ST_COMPUTE);
            busy      <= (state_next != ST_IDLE);
            done      <= (state_next == ST_DRAIN) && (cnt_next == DRAIN_LAST);
            if (w_fire)
                d_out <= w_data;
            else if (in_array)
                d_out <= '0;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [WORD_WIDTH:0] stage0, tap;

        always_ff @(posedge clk) begin
            if (reset || !act_fire)
                stage0 <= '0;
            else
                stage0 <= {act_data[r*WORD_WIDTH +: WORD_WIDTH], 1'b1};
        end

        skew_delay_line #(
            .WIDTH (WORD_WIDTH + 1),
            .DEPTH (r)
        ) u_skew (
            .clk      (clk),
            .reset    (reset),
            .in_data  (stage0),
            .out_data (tap)
        );

        assign a_out[r*WORD_WIDTH +: WORD_WIDTH] = tap[WORD_WIDTH:1];
        assign a_vld[r]                          = tap[0];
    end

`ifdef FEEDER_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || (state == ST_IDLE && w_fire)) begin
            perf_compute_cycles <= '0;
            perf_bubble_cycles  <= '0;
        end else if (state == ST_COMPUTE) begin
            perf_compute_cycles <= perf_compute_cycles + 32'd1;
            if (!act_fire)
                perf_bubble_cycles <= perf_bubble_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// tb/tb_systolic_edge_feeder.sv - randomized self-checking bench for systolic_edge_feeder
module tb_systolic_edge_feeder;

    localparam int W   = 8;
    localparam int R   = 4;
    localparam int C   = 4;
    localparam int DW  = C * W * 4;
    localparam int AW  = R * W;
    localparam int DRN = R + C - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          w_valid, w_ready;
    logic [DW-1:0] w_data;
    logic          act_valid, act_ready, act_last;
    logic [AW-1:0] act_data;
    logic [1:0]    ctrl_out;
    logic [DW-1:0] d_out;
    logic [AW-1:0] a_out;
    logic [R-1:0]  a_vld;
    logic          busy, done;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0]   perf_compute_cycles, perf_bubble_cycles;
`endif

    always #5 clk = ~clk;

    systolic_edge_feeder #(
        .WORD_WIDTH (W),
        .ROWS       (R),
        .COLS       (C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .act_data  (act_data),
        .act_last  (act_last),
        .ctrl_out  (ctrl_out),
        .d_out     (d_out),
        .a_out     (a_out),
        .a_vld     (a_vld),
        .busy      (busy),
        .done      (done)
`ifdef FEEDER_PERF_CNT_EN
        , .perf_compute_cycles (perf_compute_cycles)
        , .perf_bubble_cycles  (perf_bubble_cycles)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tile description: weight beats with idle gaps before each, vectors with bubbles before each.
    logic [DW-1:0] t_beat [R];
    int            t_wgap [R];
    logic [AW-1:0] t_vec  [$];
    int            t_agap [$];
    bit            t_noise;

    function automatic logic [DW-1:0] rand_w();
        logic [DW-1:0] x;
        for (int k = 0; k < DW; k += 32) x[k +: 32] = $urandom;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_ctrl"},  ctrl_out,  2'b00);
        check({pfx, "_d"},     d_out,     '0);
        check({pfx, "_a"},     a_out,     '0);
        check({pfx, "_vld"},   a_vld,     '0);
        check({pfx, "_busy"},  busy,      1'b0);
        check({pfx, "_done"},  done,      1'b0);
        check({pfx, "_wrdy"},  w_ready,   1'b0);
        check({pfx, "_ardy"},  act_ready, 1'b0);
    endtask

    // Expected outputs come from the event times of the tile: beat k at bcyc[k], vector j at vcyc[j].
    task automatic run_tile(input int abort_after);
        int            bcyc [R];
        int            vcyc [$];
        int            tl, tt, cur, nv;
        logic [1:0]    e_ctrl;
        logic [DW-1:0] e_d;
        logic [AW-1:0] e_a, v;
        logic [R-1:0]  e_v;

        nv  = t_vec.size();
        cur = 0;
        for (int i = 0; i < R; i++) begin
            cur += t_wgap[i];
            bcyc[i] = cur;
            cur++;
        end
        tl  = bcyc[R-1];
        cur = tl + 1;
        for (int j = 0; j < nv; j++) begin
            cur += t_agap[j];
            vcyc.push_back(cur);
            cur++;
        end
        tt = vcyc[nv-1];

        for (int t = 0; t <= tt + DRN; t++) begin
            e_ctrl = 2'b00;
            e_d    = '0;
            for (int i = 0; i < R; i++) begin
                if (bcyc[i] == t - 1) e_ctrl = 2'b01;
                if (bcyc[i] < t)      e_d    = t_beat[i];
            end
            if (t >= tl + 2) begin
                e_d    = '0;
                e_ctrl = 2'b10;
            end
            e_a = '0;
            e_v = '0;
            for (int r = 0; r < R; r++) begin
                for (int j = 0; j < nv; j++) begin
                    if (vcyc[j] == t - 1 - r) begin
                        v = t_vec[j];
                        e_a[r*W +: W] = v[r*W +: W];
                        e_v[r] = 1'b1;
                    end
                end
            end
            check("ctrl",      ctrl_out,  e_ctrl);
            check("d_out",     d_out,     e_d);
            check("a_out",     a_out,     e_a);
            check("a_vld",     a_vld,     e_v);
            check("done",      done,      t == tt + DRN);
            check("busy",      busy,      (t > bcyc[0]) && (t <= tt + DRN));
            check("w_ready",   w_ready,   t <= tl);
            check("act_ready", act_ready, (t > tl) && (t <= tt));
`ifdef FEEDER_PERF_CNT_EN
            if (t == tt + DRN) begin
                check("perf_compute", perf_compute_cycles, tt - tl);
                check("perf_bubble",  perf_bubble_cycles,  tt - tl - nv);
            end
`endif
            if (abort_after > 0 && t == vcyc[abort_after-1] + 1) begin
                reset     = 1'b1;
                w_valid   = 1'b0;
                act_valid = 1'b0;
                step();
                check_reset_state("abort");
                reset = 1'b0;
                step();
                return;
            end

            w_valid   = 1'b0;
            w_data    = rand_w();
            act_valid = 1'b0;
            act_last  = 1'($urandom);
            act_data  = $urandom;
            for (int i = 0; i < R; i++)
                if (bcyc[i] == t) begin
                    w_valid = 1'b1;
                    w_data  = t_beat[i];
                end
            if (t_noise && t > tl)
                w_valid = 1'($urandom);
            if (t_noise && (t <= tl || t > tt))
                act_valid = 1'($urandom);
            for (int j = 0; j < nv; j++)
                if (vcyc[j] == t) begin
                    act_valid = 1'b1;
                    act_data  = t_vec[j];
                    act_last  = (j == nv - 1);
                end
            step();
        end
    endtask

    task automatic set_beats_seq(input int g2);
        for (int i = 0; i < R; i++) begin
            t_beat[i] = DW'(i + 3);
            t_wgap[i] = 0;
        end
        t_wgap[2] = g2;
    endtask

    task automatic add_vec(input logic [AW-1:0] v, input int gap);
        t_vec.push_back(v);
        t_agap.push_back(gap);
    endtask

    initial begin
        reset     = 1'b1;
        w_valid   = 1'b0;
        w_data    = '0;
        act_valid = 1'b0;
        act_data  = '0;
        act_last  = 1'b0;
        t_noise   = 1'b0;
        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;
        step();

        // Beats 3..6 back-to-back, single-vector tile on the first compute cycle.
        set_beats_seq(0);
        t_vec.delete(); t_agap.delete();
        add_vec(32'h05040302, 0);
        run_tile(0);

        // Two-cycle weight gap, one bubble between vectors.
        set_beats_seq(2);
        t_vec.delete(); t_agap.delete();
        add_vec(32'h11223344, 0);
        add_vec(32'h55667788, 1);
        add_vec(32'h99aabbcc, 0);
        run_tile(0);

        // Five vectors with two bubbles.
        set_beats_seq(0);
        t_vec.delete(); t_agap.delete();
        add_vec(32'h01020304, 0);
        add_vec(32'h05060708, 1);
        add_vec(32'h090a0b0c, 0);
        add_vec(32'h0d0e0f10, 1);
        add_vec(32'h11121314, 0);
        run_tile(0);

        // Reset after two accepted vectors, then a clean tile must restart in LOAD.
        set_beats_seq(1);
        t_vec.delete(); t_agap.delete();
        for (int j = 0; j < 4; j++) add_vec($urandom, 0);
        run_tile(2);
        set_beats_seq(0);
        t_vec.delete(); t_agap.delete();
        add_vec(32'hdeadbeef, 0);
        add_vec(32'hcafef00d, 2);
        run_tile(0);

        t_noise = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < R; i++) begin
                t_beat[i] = rand_w();
                t_wgap[i] = $urandom_range(0, 2);
            end
            t_vec.delete(); t_agap.delete();
            for (int j = 0; j < int'($urandom_range(1, 6)); j++)
                add_vec($urandom, $urandom_range(0, 2));
            run_tile(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
